ddr_cmd_scheduler: RTL and testbench
====================================

Name: ddr_cmd_scheduler

Overview:
- Drains queued memory transactions from transaction_fifo and sequences them into DRAM commands (ACT, RD, WR, PRE, PREA, REF) for the PHY command path.
- Uses an open-page policy: tracks the open row of each bank and enforces tRP, tRCD, tCCD and tRFC spacing.
- Optionally inserts periodic refresh.
- Sits between transaction_fifo (read side) and the PHY command interface.

Parameters:
- NUM_BANKS, 4, number of banks; power of 2.
- ROW_W, 14, row address width.
- COL_W, 10, column address width.
- T_RP, 3, minimum cycles from PRE/PREA to ACT/REF; must be ≥2.
- T_RCD, 3, minimum cycles from ACT to RD/WR on that bank; must be ≥2.
- T_CCD, 2, minimum cycles between consecutive RD/WR; must be ≥2.
- T_RFC, 20, minimum cycles from REF to next command; must be ≥2.
- T_REFI, 780, refresh interval in cycles; refresh builds only.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- n_rst  in  1  asynchronous, active-low reset.
- txn_valid  in  1  FIFO head valid (FIFO not empty).
- txn_we  in  1  head is a write (1) or a read (0).
- txn_bank  in  $clog2(NUM_BANKS)  head bank.
- txn_row  in  ROW_W  head row.
- txn_col  in  COL_W  head column.
- txn_pop  out  1  one-cycle pop strobe to the FIFO.
- cmd_valid  out  1  command strobe.
- cmd  out  3  cmd_t encoding.
- cmd_bank  out  $clog2(NUM_BANKS)  command bank.
- cmd_row  out  ROW_W  valid with ACT.
- cmd_col  out  COL_W  valid with RD/WR.
- busy  out  1  high when not in IDLE or a command is pending.

Behaviour:
- Reset values:
  - All outputs 0; cmd = NOP.
  - All banks closed; wait counter 0; refresh counter 0; ref_pending 0.
  - FSM in IDLE.
- All outputs are registered. At most one command is issued per cycle.
- Spacing rule: every "≥T" below is measured between cmd_valid cycles.
- FSM states: IDLE, WAIT, REF_PRE, REF_WAIT.
- Decision point: FSM in IDLE and wait counter = 0. Priority at each decision point:
  1. ref_pending (refresh builds only) → go to REF_PRE.
  2. txn_valid and bank open with row == txn_row (hit):
     - Issue RD (txn_we=0) or WR (txn_we=1) with txn_bank/txn_col.
     - Assert txn_pop in the same cycle as cmd_valid.
     - Load spacing T_CCD.
  3. txn_valid and bank open with a different row (conflict):
     - Issue PRE to txn_bank; mark the bank closed; load T_RP.
     - No pop.
  4. txn_valid and bank closed (miss):
     - Issue ACT with txn_bank/txn_row; record the row as open; load T_RCD.
     - No pop.
  5. None of the above → cmd_valid = 0.
- Latency: a hit on an idle scheduler produces cmd_valid on the cycle after the decision cycle.
  - Miss latency: 1 + T_RCD cycles to the RD/WR.
  - Conflict latency: 1 + T_RP + T_RCD cycles to the RD/WR.
- A conflict or miss never pops. The same head is re-evaluated after the wait, so every transaction ends in exactly one RD/WR and exactly one pop.
- Pop/head interaction: the FIFO head updates the cycle after txn_pop. T_CCD ≥ 2 guarantees the next decision sees the new head.
- The wait counter is global (conservative). It counts down to 0 and never underflows.
- txn_* inputs are sampled only at decision points. Changes at other times are ignored.
- Reset mid-sequence:
  - In-flight sequence abandoned; no pop issued.
  - All banks treated as closed; outputs return to reset values on the assertion edge.

Optional Feature:
- Macro DDR_SCHED_REFRESH_EN.
- Defined:
  - A free-running counter sets ref_pending when it reaches T_REFI−1, then wraps to 0.
  - REF_PRE: if any bank is open, issue PREA, close all banks and wait T_RP. Otherwise skip PREA.
  - REF_WAIT: issue REF, clear ref_pending, wait T_RFC, then return to IDLE.
  - Refresh takes priority over a pending head, but is taken only at a decision point; it never interrupts spacing.
  - If T_REFI expires again while ref_pending is set, the requests merge into one refresh.
- Undefined:
  - No refresh counter, no REF_* states, no ref_pending.
  - PREA and REF are never issued.
  - The T_REFI and T_RFC parameters are ignored.

Decomposition:
- Package ddr_pkg holds:
  - cmd_t enum: NOP=0, ACT=1, RD=2, WR=3, PRE=4, PREA=5, REF=6.
  - Default timing and width constants.
  - The sched_state_t enum.
- One natural sub-module, ddr_bank_tracker:
  - Per-bank open flag and row register.
  - Hit/conflict/miss lookup for (bank, row).
  - Open, close and close-all strobes.

Test Plan:
- Read miss: reset, present txn_valid=1, we=0, bank 1, row 0x12, col 0x40 → ACT b1 r0x12, then RD b1 c0x40 exactly T_RCD=3 cycles later with txn_pop=1 in that cycle.
- Row hit: after the above, present bank 1, row 0x12, col 0x44 as a write → WR b1 c0x44 issued T_CCD=2 after the previous RD; no ACT.
- Conflict: present bank 1, row 0x99 → PRE b1, ACT b1 r0x99 after T_RP=3, RD/WR after T_RCD=3 more; exactly one pop.
- Empty FIFO: txn_valid=0 for 50 cycles (refresh off) → cmd_valid stays 0, busy=0.
- Refresh (macro on, T_REFI=40): bank 2 open → at the first decision point after cycle 39, PREA, then REF T_RP later, then no command for T_RFC cycles; bank 2 re-ACTed for its next access.
- Reset mid-sequence: assert n_rst low the cycle after ACT → outputs 0 immediately; after release the same head gets a fresh ACT (bank closed).

Source files
------------

// File: rtl/ddr_pkg.sv
// ddr_pkg: shared types and constants for the DDR command scheduler.
//   cmd_t         - PHY command encoding (NOP, ACT, RD, WR, PRE, PREA, REF)
//   sched_state_t - scheduler FSM states
//   DEF_*         - default widths and timing intervals
//   max_int       - helper for sizing counters from several intervals
package ddr_pkg;

    localparam int DEF_NUM_BANKS = 4;
    localparam int DEF_ROW_W     = 14;
    localparam int DEF_COL_W     = 10;
    localparam int DEF_T_RP      = 3;
    localparam int DEF_T_RCD     = 3;
    localparam int DEF_T_CCD     = 2;
    localparam int DEF_T_RFC     = 20;
    localparam int DEF_T_REFI    = 780;

    typedef enum logic [2:0] {
        NOP  = 3'd0,
        ACT  = 3'd1,
        RD   = 3'd2,
        WR   = 3'd3,
        PRE  = 3'd4,
        PREA = 3'd5,
        REF  = 3'd6
    } cmd_t;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT     = 2'd1,
        REF_PRE  = 2'd2,
        REF_WAIT = 2'd3
    } sched_state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/ddr_bank_tracker.sv
// ddr_bank_tracker: per-bank open flag and open-row register, with a
// combinational hit/conflict/miss lookup for the presented (bank, row).
// Optional macro DDR_SCHED_REFRESH_EN adds the close-all strobe and the
// any-bank-open flag used by the refresh sequence.
// Ports:
//   clk, n_rst      clock, asynchronous active-low reset (all banks closed)
//   i_close_all     (refresh builds) close every bank
//   o_any_open      (refresh builds) at least one bank is open
//   i_bank, i_row   lookup and update address
//   i_open          mark i_bank open with row i_row
//   i_close         mark i_bank closed
//   o_hit           i_bank open on i_row
//   o_conflict      i_bank open on another row
//   o_miss          i_bank closed
module ddr_bank_tracker
    import ddr_pkg::*;
#(
    parameter int NUM_BANKS = DEF_NUM_BANKS,
    parameter int ROW_W     = DEF_ROW_W
) (
    input  logic                         clk,
    input  logic                         n_rst,
`ifdef DDR_SCHED_REFRESH_EN
    input  logic                         i_close_all,
    output logic                         o_any_open,
`endif
    input  logic [$clog2(NUM_BANKS)-1:0] i_bank,
    input  logic [ROW_W-1:0]             i_row,
    input  logic                         i_open,
    input  logic                         i_close,
    output logic                         o_hit,
    output logic                         o_conflict,
    output logic                         o_miss
);

    logic [NUM_BANKS-1:0] r_open;
    logic [ROW_W-1:0]     r_row [NUM_BANKS];
    logic                 w_close_all;

`ifdef DDR_SCHED_REFRESH_EN
    assign w_close_all = i_close_all;
    assign o_any_open  = |r_open;
`else
    assign w_close_all = 1'b0;
`endif

    // Bank state update; close-all wins over a single-bank strobe.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_open <= '0;
            for (int b = 0; b < NUM_BANKS; b++) begin
                r_row[b] <= '0;
            end
        end else if (w_close_all) begin
            r_open <= '0;
        end else if (i_close) begin
            r_open[i_bank] <= 1'b0;
        end else if (i_open) begin
            r_open[i_bank] <= 1'b1;
            r_row[i_bank]  <= i_row;
        end
    end

    // Lookup of the presented address against the open-row table.
    always_comb begin
        o_hit      = 1'b0;
        o_conflict = 1'b0;
        o_miss     = 1'b0;
        if (r_open[i_bank]) begin
            if (r_row[i_bank] == i_row) begin
                o_hit = 1'b1;
            end else begin
                o_conflict = 1'b1;
            end
        end else begin
            o_miss = 1'b1;
        end
    end

endmodule

// File: rtl/ddr_cmd_scheduler.sv
// ddr_cmd_scheduler: drains the transaction FIFO head and issues DRAM
// commands with an open-page policy, enforcing tRP/tRCD/tCCD/tRFC with one
// global countdown. All outputs are registered: a decision made in IDLE with
// the wait counter at zero appears on cmd_* one cycle later.
// Optional macro DDR_SCHED_REFRESH_EN enables periodic refresh (PREA + REF).
// Ports:
//   clk, n_rst                    clock, asynchronous active-low reset
//   txn_valid/we/bank/row/col     FIFO head (sampled only at decision points)
//   txn_pop                       one-cycle pop strobe, coincident with RD/WR
//   cmd_valid/cmd/bank/row/col    PHY command (row valid with ACT, col with RD/WR)
//   busy                          FSM not idle or spacing still running
module ddr_cmd_scheduler
    import ddr_pkg::*;
#(
    parameter int NUM_BANKS = DEF_NUM_BANKS,
    parameter int ROW_W     = DEF_ROW_W,
    parameter int COL_W     = DEF_COL_W,
    parameter int T_RP      = DEF_T_RP,
    parameter int T_RCD     = DEF_T_RCD,
    parameter int T_CCD     = DEF_T_CCD,
    parameter int T_RFC     = DEF_T_RFC,
    parameter int T_REFI    = DEF_T_REFI
) (
    input  logic                         clk,
    input  logic                         n_rst,
    input  logic                         txn_valid,
    input  logic                         txn_we,
    input  logic [$clog2(NUM_BANKS)-1:0] txn_bank,
    input  logic [ROW_W-1:0]             txn_row,
    input  logic [COL_W-1:0]             txn_col,
    output logic                         txn_pop,
    output logic                         cmd_valid,
    output logic [2:0]                   cmd,
    output logic [$clog2(NUM_BANKS)-1:0] cmd_bank,
    output logic [ROW_W-1:0]             cmd_row,
    output logic [COL_W-1:0]             cmd_col,
    output logic                         busy
);

    localparam int BANK_W = $clog2(NUM_BANKS);
    // One width covers every interval this block times, refresh included.
    localparam int CNT_W  = $clog2(max_int(max_int(T_REFI, T_RFC),
                                           max_int(max_int(T_RP, T_RCD), T_CCD))) + 1;

    // A load of T-1 puts the next decision T cycles after this one, so the
    // registered commands are exactly T cycles apart.
    localparam logic [CNT_W-1:0] LD_RP  = CNT_W'(T_RP - 1);
    localparam logic [CNT_W-1:0] LD_RCD = CNT_W'(T_RCD - 1);
    localparam logic [CNT_W-1:0] LD_CCD = CNT_W'(T_CCD - 1);

    sched_state_t       r_state, w_state_n;
    logic [CNT_W-1:0]   r_cnt, w_cnt_n;
    logic               r_cmd_valid, w_cmd_valid_n;
    cmd_t               r_cmd, w_cmd_n;
    logic [BANK_W-1:0]  r_cmd_bank, w_cmd_bank_n;
    logic [ROW_W-1:0]   r_cmd_row, w_cmd_row_n;
    logic [COL_W-1:0]   r_cmd_col, w_cmd_col_n;
    logic               r_txn_pop, w_txn_pop_n;
    logic               r_busy, w_busy_n;

    logic               w_open, w_close;
    logic               w_hit, w_conflict, w_miss;
    logic               w_ref_req;

`ifdef DDR_SCHED_REFRESH_EN
    localparam logic [CNT_W-1:0] LD_RFC   = CNT_W'(T_RFC - 1);
    localparam logic [CNT_W-1:0] REF_LAST = CNT_W'(T_REFI - 1);

    logic [CNT_W-1:0]   r_ref_cnt;
    logic               r_ref_pending;
    logic               w_close_all, w_any_open, w_ref_clr;

    assign w_ref_req = r_ref_pending;

    // Free-running refresh interval; a new expiry merges into a pending one.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_ref_cnt     <= '0;
            r_ref_pending <= 1'b0;
        end else if (r_ref_cnt == REF_LAST) begin
            r_ref_cnt     <= '0;
            r_ref_pending <= 1'b1;
        end else begin
            r_ref_cnt     <= r_ref_cnt + CNT_W'(1);
            r_ref_pending <= r_ref_pending & ~w_ref_clr;
        end
    end
`else
    assign w_ref_req = 1'b0;
`endif

    ddr_bank_tracker #(
        .NUM_BANKS (NUM_BANKS),
        .ROW_W     (ROW_W)
    ) u_bank_tracker (
        .clk         (clk),
        .n_rst       (n_rst),
`ifdef DDR_SCHED_REFRESH_EN
        .i_close_all (w_close_all),
        .o_any_open  (w_any_open),
`endif
        .i_bank      (txn_bank),
        .i_row       (txn_row),
        .i_open      (w_open),
        .i_close     (w_close),
        .o_hit       (w_hit),
        .o_conflict  (w_conflict),
        .o_miss      (w_miss)
    );

    // Next-state and next-command decode.
    always_comb begin
        w_state_n     = r_state;
        w_cnt_n       = r_cnt;
        w_cmd_valid_n = 1'b0;
        w_cmd_n       = NOP;
        w_cmd_bank_n  = '0;
        w_cmd_row_n   = '0;
        w_cmd_col_n   = '0;
        w_txn_pop_n   = 1'b0;
        w_open        = 1'b0;
        w_close       = 1'b0;
`ifdef DDR_SCHED_REFRESH_EN
        w_close_all   = 1'b0;
        w_ref_clr     = 1'b0;
`endif
        case (r_state)
            IDLE: begin
                if (r_cnt != '0) begin
                    w_cnt_n = r_cnt - CNT_W'(1);
                end else if (w_ref_req) begin
                    w_state_n = REF_PRE;
                end else if (txn_valid && w_hit) begin
                    w_cmd_valid_n = 1'b1;
                    w_cmd_n       = txn_we ? WR : RD;
                    w_cmd_bank_n  = txn_bank;
                    w_cmd_col_n   = txn_col;
                    w_txn_pop_n   = 1'b1;
                    w_cnt_n       = LD_CCD;
                    w_state_n     = WAIT;
                end else if (txn_valid && w_conflict) begin
                    w_cmd_valid_n = 1'b1;
                    w_cmd_n       = PRE;
                    w_cmd_bank_n  = txn_bank;
                    w_close       = 1'b1;
                    w_cnt_n       = LD_RP;
                    w_state_n     = WAIT;
                end else if (txn_valid && w_miss) begin
                    w_cmd_valid_n = 1'b1;
                    w_cmd_n       = ACT;
                    w_cmd_bank_n  = txn_bank;
                    w_cmd_row_n   = txn_row;
                    w_open        = 1'b1;
                    w_cnt_n       = LD_RCD;
                    w_state_n     = WAIT;
                end else begin
                    w_state_n = IDLE;
                end
            end
            WAIT: begin
                if (r_cnt <= CNT_W'(1)) begin
                    w_cnt_n   = '0;
                    w_state_n = IDLE;
                end else begin
                    w_cnt_n = r_cnt - CNT_W'(1);
                end
            end
`ifdef DDR_SCHED_REFRESH_EN
            REF_PRE: begin
                // PREA only when something is open; otherwise straight to REF.
                if (w_any_open) begin
                    w_cmd_valid_n = 1'b1;
                    w_cmd_n       = PREA;
                    w_close_all   = 1'b1;
                    w_cnt_n       = LD_RP;
                end else begin
                    w_cnt_n = '0;
                end
                w_state_n = REF_WAIT;
            end
            REF_WAIT: begin
                if (r_cnt != '0) begin
                    w_cnt_n = r_cnt - CNT_W'(1);
                end else begin
                    w_cmd_valid_n = 1'b1;
                    w_cmd_n       = REF;
                    w_ref_clr     = 1'b1;
                    w_cnt_n       = LD_RFC;
                    w_state_n     = WAIT;
                end
            end
`endif
            default: begin
                w_state_n = IDLE;
                w_cnt_n   = '0;
            end
        endcase
        w_busy_n = (w_state_n != IDLE) || (w_cnt_n != '0);
    end

    // State, counter and registered outputs.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_cmd_valid <= 1'b0;
            r_cmd       <= NOP;
            r_cmd_bank  <= '0;
            r_cmd_row   <= '0;
            r_cmd_col   <= '0;
            r_txn_pop   <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_n;
            r_cnt       <= w_cnt_n;
            r_cmd_valid <= w_cmd_valid_n;
            r_cmd       <= w_cmd_n;
            r_cmd_bank  <= w_cmd_bank_n;
            r_cmd_row   <= w_cmd_row_n;
            r_cmd_col   <= w_cmd_col_n;
            r_txn_pop   <= w_txn_pop_n;
            r_busy      <= w_busy_n;
        end
    end

    assign txn_pop   = r_txn_pop;
    assign cmd_valid = r_cmd_valid;
    assign cmd       = r_cmd;
    assign cmd_bank  = r_cmd_bank;
    assign cmd_row   = r_cmd_row;
    assign cmd_col   = r_cmd_col;
    assign busy      = r_busy;

endmodule

// File: tb/tb_ddr_cmd_scheduler.sv
// Self-checking bench for ddr_cmd_scheduler. A FIFO model feeds the head;
// expected commands (with spacing from the previous command) are queued when
// stimulus is applied and compared as the DUT issues commands.
module tb_ddr_cmd_scheduler;
    import ddr_pkg::*;

    logic        clk = 1'b0;
    logic        n_rst;
    logic        txn_valid, txn_we;
    logic [1:0]  txn_bank;
    logic [13:0] txn_row;
    logic [9:0]  txn_col;
    logic        txn_pop, cmd_valid, busy;
    logic [2:0]  cmd;
    logic [1:0]  cmd_bank;
    logic [13:0] cmd_row;
    logic [9:0]  cmd_col;

    always #5 clk = ~clk;

    ddr_cmd_scheduler #(
        .NUM_BANKS(4), .ROW_W(14), .COL_W(10),
        .T_RP(3), .T_RCD(3), .T_CCD(2), .T_RFC(20), .T_REFI(40)
    ) dut (
        .clk(clk), .n_rst(n_rst),
        .txn_valid(txn_valid), .txn_we(txn_we), .txn_bank(txn_bank),
        .txn_row(txn_row), .txn_col(txn_col), .txn_pop(txn_pop),
        .cmd_valid(cmd_valid), .cmd(cmd), .cmd_bank(cmd_bank),
        .cmd_row(cmd_row), .cmd_col(cmd_col), .busy(busy)
    );

    typedef struct { int we; int bank; int row; int col; } txn_s;
    typedef struct { int cmd; int bank; int row; int col; int pop; int gap; } exp_s;

    txn_s fifo_q[$];
    exp_s exp_q[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   last_cyc = 0;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    task automatic drive_head();
        if (fifo_q.size() > 0) begin
            txn_valid = 1'b1;
            txn_we    = fifo_q[0].we[0];
            txn_bank  = fifo_q[0].bank[1:0];
            txn_row   = fifo_q[0].row[13:0];
            txn_col   = fifo_q[0].col[9:0];
        end else begin
            txn_valid = 1'b0;
            txn_we    = 1'b0;
            txn_bank  = 2'd0;
            txn_row   = 14'd0;
            txn_col   = 10'd0;
        end
    endtask

    task automatic push_txn(input int we, input int bank, input int row, input int col);
        txn_s t;
        t.we = we; t.bank = bank; t.row = row; t.col = col;
        fifo_q.push_back(t);
        drive_head();
    endtask

    task automatic push_exp(input cmd_t c, input int bank, input int row, input int col,
                            input int pop, input int gap);
        exp_s e;
        e.cmd = int'(c); e.bank = bank; e.row = row; e.col = col; e.pop = pop; e.gap = gap;
        exp_q.push_back(e);
    endtask

    // One clock: sample at the falling edge, score any command, update the FIFO.
    task automatic tick();
        exp_s e;
        @(negedge clk);
        cyc++;
        if (cmd_valid) begin
            if (exp_q.size() == 0) begin
                check_val("unexpected_cmd_valid", 32'(cmd_valid), 32'd0);
            end else begin
                e = exp_q.pop_front();
                check_val("cmd", 32'(cmd), 32'(e.cmd));
                check_val("cmd_bank", 32'(cmd_bank), 32'(e.bank));
                if (e.cmd == int'(ACT)) check_val("cmd_row", 32'(cmd_row), 32'(e.row));
                if (e.cmd == int'(RD) || e.cmd == int'(WR)) check_val("cmd_col", 32'(cmd_col), 32'(e.col));
                check_val("txn_pop", 32'(txn_pop), 32'(e.pop));
                if (e.gap > 0) check_val("cmd_spacing", 32'(cyc - last_cyc), 32'(e.gap));
            end
            last_cyc = cyc;
        end else if (txn_pop) begin
            check_val("stray_pop", 32'(txn_pop), 32'd0);
        end
        if (txn_pop && fifo_q.size() > 0) begin
            void'(fifo_q.pop_front());
            drive_head();
        end
    endtask

    // Run until every expected command has appeared, then some quiet cycles.
    task automatic drain(input int budget, input int extra);
        for (int i = 0; i < budget && exp_q.size() > 0; i++) tick();
        if (exp_q.size() > 0) begin
            check_val("timeout_pending_cmds", 32'(exp_q.size()), 32'd0);
            exp_q.delete();
        end
        for (int i = 0; i < extra; i++) tick();
    endtask

    task automatic check_outputs_reset(input string pfx);
        check_val({pfx, "_cmd_valid"}, 32'(cmd_valid), 32'd0);
        check_val({pfx, "_cmd"}, 32'(cmd), 32'(NOP));
        check_val({pfx, "_cmd_bank"}, 32'(cmd_bank), 32'd0);
        check_val({pfx, "_cmd_row"}, 32'(cmd_row), 32'd0);
        check_val({pfx, "_cmd_col"}, 32'(cmd_col), 32'd0);
        check_val({pfx, "_txn_pop"}, 32'(txn_pop), 32'd0);
        check_val({pfx, "_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        n_rst = 1'b0;
        drive_head();
        for (int i = 0; i < 3; i++) tick();
        check_outputs_reset("reset");
        n_rst = 1'b1;
        tick();
        tick();

`ifdef DDR_SCHED_REFRESH_EN
        // Open bank 2, then let the refresh interval expire.
        last_cyc = cyc;
        push_txn(0, 2, 14'h007, 10'h003);
        push_exp(ACT, 2, 14'h007, 0, 0, 1);
        push_exp(RD, 2, 0, 10'h003, 1, 3);
        push_exp(PREA, 0, 0, 0, 0, 0);
        push_exp(REF, 0, 0, 0, 0, 3);
        drain(80, 0);
        // Same row again: the bank was closed by PREA, so it is re-activated
        // only after tRFC.
        push_txn(1, 2, 14'h007, 10'h005);
        push_exp(ACT, 2, 14'h007, 0, 0, 20);
        push_exp(WR, 2, 0, 10'h005, 1, 3);
        drain(40, 6);
        check_val("refresh_fifo_drained", 32'(fifo_q.size()), 32'd0);
`else
        // Read miss followed by a write hit on the same row.
        last_cyc = cyc;
        push_txn(0, 1, 14'h012, 10'h040);
        push_txn(1, 1, 14'h012, 10'h044);
        push_exp(ACT, 1, 14'h012, 0, 0, 1);
        push_exp(RD, 1, 0, 10'h040, 1, 3);
        push_exp(WR, 1, 0, 10'h044, 1, 2);
        drain(40, 8);

        // Row conflict on bank 1.
        last_cyc = cyc;
        push_txn(0, 1, 14'h099, 10'h008);
        push_exp(PRE, 1, 0, 0, 0, 1);
        push_exp(ACT, 1, 14'h099, 0, 0, 3);
        push_exp(RD, 1, 0, 10'h008, 1, 3);
        drain(40, 8);

        // Miss on another bank, then a hit back on bank 1.
        last_cyc = cyc;
        push_txn(1, 3, 14'h005, 10'h001);
        push_txn(0, 1, 14'h099, 10'h002);
        push_exp(ACT, 3, 14'h005, 0, 0, 1);
        push_exp(WR, 3, 0, 10'h001, 1, 3);
        push_exp(RD, 1, 0, 10'h002, 1, 2);
        drain(40, 8);
        check_val("fifo_drained", 32'(fifo_q.size()), 32'd0);

        // Empty FIFO: nothing issued, not busy.
        for (int i = 0; i < 50; i++) begin
            tick();
            check_val("idle_busy", 32'(busy), 32'd0);
        end

        // Reset the cycle after an ACT; the head must be re-activated.
        last_cyc = cyc;
        push_txn(0, 2, 14'h033, 10'h010);
        push_exp(ACT, 2, 14'h033, 0, 0, 1);
        drain(10, 0);
        tick();
        check_val("pre_reset_busy", 32'(busy), 32'd1);
        n_rst = 1'b0;
        #1;
        check_outputs_reset("midreset");
        tick();
        tick();
        n_rst = 1'b1;
        last_cyc = cyc;
        push_exp(ACT, 2, 14'h033, 0, 0, 1);
        push_exp(RD, 2, 0, 10'h010, 1, 3);
        drain(20, 8);
        check_val("reset_fifo_drained", 32'(fifo_q.size()), 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
